dmem_arbiter: RTL and testbench

- Two-port arbiter and sequencer in front of the single-port data memory (word array, combinational read, write on posedge clk when write enable is high).
- Port 0 is the pipeline MEM-stage load/store unit (core); port 1 is an auxiliary master such as a program loader or debug/DMA engine (aux).
- The block issues at most one memory access per cycle, converts byte addresses to word indices, and rejects out-of-range or misaligned accesses.
- It registers read data back to the winning port, prevents starvation of aux, and supports locked aux bursts.

---
 rtl/dmem_arbiter.sv | 97 +++++++++
 tb/tb_dmem_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter/sequencer for the single-port data memory
// Core and aux share one access per cycle; aux has anti-starvation and locked bursts.
module dmem_arbiter #(
    parameter int DEPTH        = 1024,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic        core_gnt,
    output logic        core_rvalid,
    output logic        core_err,
    input  logic        aux_req,
    input  logic        aux_we,
    input  logic [31:0] aux_addr,
    input  logic [31:0] aux_wdata,
    input  logic        aux_lock,
    output logic        aux_gnt,
    output logic        aux_rvalid,
    output logic        aux_err,
    output logic [31:0] rdata,
    output logic [31:0] mem_A,
    output logic [31:0] mem_writeData,
    output logic        mem_writeEnable,
    input  logic [31:0] mem_RD
);

    typedef enum logic {ARB, AUX_LOCK} state_t;

    localparam logic [3:0]  LIMIT   = 4'(STARVE_LIMIT);
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    state_t      state, state_nxt;
    logic [3:0]  starve_cnt, starve_nxt;
    logic        lock_hold;
    logic        any_gnt;
    logic        sel_we;
    logic        bad;
    logic [31:0] sel_addr;

    always_comb begin
        core_gnt   = 1'b0;
        aux_gnt    = 1'b0;
        state_nxt  = ARB;
        starve_nxt = 4'd0;
        // Lock only persists while aux keeps asserting aux_lock; the release cycle arbitrates normally.
        lock_hold  = (state == AUX_LOCK) && aux_lock;
        if (!rst) begin
            if (lock_hold)
                aux_gnt = aux_req;
            else if (aux_req && starve_cnt == LIMIT)
                aux_gnt = 1'b1;
            else if (core_req)
                core_gnt = 1'b1;
            else
                aux_gnt = aux_req;
        end
        if (lock_hold || (aux_gnt && aux_lock))
            state_nxt = AUX_LOCK;
        if (aux_req && !aux_gnt)
            starve_nxt = (starve_cnt == LIMIT) ? LIMIT : starve_cnt + 4'd1;
    end

    assign any_gnt  = core_gnt | aux_gnt;
    assign sel_addr = aux_gnt ? aux_addr : core_addr;
    assign sel_we   = aux_gnt ? aux_we : core_we;
    assign bad      = (sel_addr[1:0] != 2'b00) || ({2'b00, sel_addr[31:2]} >= DEPTH_W);

    assign mem_A           = {2'b00, sel_addr[31:2]};
    assign mem_writeData   = aux_gnt ? aux_wdata : core_wdata;
    assign mem_writeEnable = any_gnt & sel_we & ~bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ARB;
            starve_cnt  <= 4'd0;
            rdata       <= 32'd0;
            core_rvalid <= 1'b0;
            core_err    <= 1'b0;
            aux_rvalid  <= 1'b0;
            aux_err     <= 1'b0;
        end else begin
            state       <= state_nxt;
            starve_cnt  <= starve_nxt;
            core_rvalid <= core_gnt;
            core_err    <= core_gnt & bad;
            aux_rvalid  <= aux_gnt;
            aux_err     <= aux_gnt & bad;
            if (any_gnt)
                rdata <= (sel_we || bad) ? 32'd0 : mem_RD;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
// Reference model of grant/starvation/lock rules plus directed literal checks.
module tb_dmem_arbiter;

    localparam int DEPTH = 1024;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req, core_we, core_gnt, core_rvalid, core_err;
    logic [31:0] core_addr, core_wdata;
    logic        aux_req, aux_we, aux_lock, aux_gnt, aux_rvalid, aux_err;
    logic [31:0] aux_addr, aux_wdata;
    logic [31:0] rdata, mem_A, mem_writeData, mem_RD;
    logic        mem_writeEnable;

    int pass_cnt = 0;
    int total    = 0;

    logic [31:0] mem     [DEPTH] = '{default: 32'h0};
    logic [31:0] ref_mem [DEPTH] = '{default: 32'h0};

    always #5 clk = ~clk;

    dmem_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_err(core_err),
        .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
        .aux_lock(aux_lock), .aux_gnt(aux_gnt), .aux_rvalid(aux_rvalid), .aux_err(aux_err),
        .rdata(rdata), .mem_A(mem_A), .mem_writeData(mem_writeData),
        .mem_writeEnable(mem_writeEnable), .mem_RD(mem_RD)
    );

    // Memory the DUT drives: combinational read, write on posedge.
    assign mem_RD = (mem_A < 32'(DEPTH)) ? mem[mem_A[9:0]] : 32'h0;
    always @(posedge clk)
        if (mem_writeEnable && mem_A < 32'(DEPTH))
            mem[mem_A[9:0]] <= mem_writeData;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference model, evaluated mid-cycle.
    bit          m_lock;
    int          m_cnt;
    bit          e_crv, e_cerr, e_arv, e_aerr;
    logic [31:0] e_rdata;

    always @(negedge clk) begin
        bit          locked, we, bad;
        int          win;
        logic [31:0] a, wd;
        if (rst) begin
            chk("rst_core_gnt", core_gnt, 0);
            chk("rst_aux_gnt", aux_gnt, 0);
            chk("rst_mem_we", mem_writeEnable, 0);
            chk("rst_core_rvalid", core_rvalid, 0);
            chk("rst_aux_rvalid", aux_rvalid, 0);
            chk("rst_rdata", rdata, 0);
            m_lock = 0; m_cnt = 0;
            e_crv = 0; e_cerr = 0; e_arv = 0; e_aerr = 0; e_rdata = 0;
        end else begin
            chk("m_core_rvalid", core_rvalid, e_crv);
            chk("m_core_err", core_err, e_cerr);
            chk("m_aux_rvalid", aux_rvalid, e_arv);
            chk("m_aux_err", aux_err, e_aerr);
            chk("m_rdata", rdata, e_rdata);
            locked = m_lock && aux_lock;
            if (locked)                      win = aux_req ? 2 : 0;
            else if (aux_req && m_cnt >= LIMIT) win = 2;
            else if (core_req)               win = 1;
            else if (aux_req)                win = 2;
            else                             win = 0;
            chk("m_core_gnt", core_gnt, (win == 1));
            chk("m_aux_gnt", aux_gnt, (win == 2));
            e_crv = (win == 1); e_arv = (win == 2);
            e_cerr = 0; e_aerr = 0;
            if (win != 0) begin
                a   = (win == 2) ? aux_addr : core_addr;
                we  = (win == 2) ? aux_we : core_we;
                wd  = (win == 2) ? aux_wdata : core_wdata;
                bad = (a % 4 != 0) || (a / 4 >= DEPTH);
                chk("m_mem_we", mem_writeEnable, (we && !bad));
                chk("m_mem_A", mem_A, a / 4);
                if (we && !bad) chk("m_mem_wdata", mem_writeData, wd);
                e_cerr  = (win == 1) && bad;
                e_aerr  = (win == 2) && bad;
                e_rdata = (we || bad) ? 32'h0 : ref_mem[a / 4];
                if (we && !bad) ref_mem[a / 4] = wd;
            end else begin
                chk("m_mem_we_idle", mem_writeEnable, 0);
            end
            m_lock = locked || (win == 2 && aux_lock);
            m_cnt  = (aux_req && win != 2) ? ((m_cnt + 1 > LIMIT) ? LIMIT : m_cnt + 1) : 0;
        end
    end

    initial begin
        rst = 1;
        core_req = 1; core_we = 0; core_addr = 0; core_wdata = 0;
        aux_req = 0; aux_we = 0; aux_addr = 0; aux_wdata = 0; aux_lock = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_gnt_gated", core_gnt, 0);
        chk("reset_rvalid", core_rvalid, 0);
        chk("reset_rdata", rdata, 0);
        rst = 0; core_req = 0;

        // Core store then load of 0x10.
        cyc();
        core_req = 1; core_we = 1; core_addr = 32'h10; core_wdata = 32'hDEADBEEF;
        #1;
        chk("st_gnt", core_gnt, 1);
        chk("st_mem_A", mem_A, 4);
        chk("st_mem_we", mem_writeEnable, 1);
        cyc();
        core_we = 0;
        #1;
        chk("ld_mem_we", mem_writeEnable, 0);
        chk("st_rvalid", core_rvalid, 1);
        chk("st_rdata_zero", rdata, 0);
        cyc();
        core_req = 0;
        #1;
        chk("ld_rvalid", core_rvalid, 1);
        chk("ld_err", core_err, 0);
        chk("ld_rdata", rdata, 32'hDEADBEEF);

        // Both requesting continuously: C,C,C,C,A repeating.
        cyc();
        core_req = 1; core_we = 0; core_addr = 0;
        aux_req = 1; aux_we = 0; aux_addr = 4;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("starve_aux_gnt", aux_gnt, (i % 5 == 4));
            chk("starve_core_gnt", core_gnt, (i % 5 != 4));
            cyc();
        end
        core_req = 0; aux_req = 0;
        cyc();

        // Locked aux burst of 3 stores with core waiting.
        core_req = 1; core_we = 0; core_addr = 0;
        aux_req = 1; aux_we = 1; aux_lock = 1; aux_addr = 0; aux_wdata = 32'hA0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("prelock_core", core_gnt, 1);
            cyc();
        end
        #1;
        chk("beat0_aux", aux_gnt, 1);
        cyc();
        aux_addr = 4; aux_wdata = 32'hA4;
        #1;
        chk("beat1_aux", aux_gnt, 1);
        chk("beat1_core", core_gnt, 0);
        cyc();
        aux_addr = 8; aux_wdata = 32'hA8;
        #1;
        chk("beat2_aux", aux_gnt, 1);
        chk("beat2_core", core_gnt, 0);
        cyc();
        aux_req = 0;
        #1;
        chk("lock_idle_aux", aux_gnt, 0);
        chk("lock_idle_core", core_gnt, 0);
        cyc();
        aux_lock = 0;
        #1;
        chk("unlock_core", core_gnt, 1);
        cyc();
        core_req = 0;

        // Rejected accesses.
        core_req = 1; core_addr = 32'h10;
        #1;
        chk("bad_pre_gnt", core_gnt, 1);
        cyc();
        core_req = 0;
        aux_req = 1; aux_we = 1; aux_addr = 32'h1002; aux_wdata = 32'hBAD;
        #1;
        chk("bad1_gnt", aux_gnt, 1);
        chk("bad1_mem_we", mem_writeEnable, 0);
        chk("bad_pre_rdata", rdata, 32'hDEADBEEF);
        cyc();
        aux_addr = 32'h12; aux_wdata = 32'hBAD2;
        #1;
        chk("bad2_mem_we", mem_writeEnable, 0);
        chk("bad1_rvalid", aux_rvalid, 1);
        chk("bad1_err", aux_err, 1);
        chk("bad1_rdata", rdata, 0);
        cyc();
        aux_req = 0; aux_we = 0;
        core_req = 1; core_we = 0; core_addr = 32'h1000;
        #1;
        chk("bad2_err", aux_err, 1);
        cyc();
        core_addr = 32'h10;
        #1;
        chk("bad3_rvalid", core_rvalid, 1);
        chk("bad3_err", core_err, 1);
        chk("bad3_rdata", rdata, 0);
        cyc();
        core_req = 0;
        #1;
        chk("bad_no_write", rdata, 32'hDEADBEEF);
        chk("bad_after_err", core_err, 0);
        cyc();

        // Reset in the middle of a lock with a core store pending.
        aux_req = 1; aux_lock = 1; aux_we = 0; aux_addr = 8;
        #1;
        chk("rlock_gnt", aux_gnt, 1);
        cyc();
        core_req = 1; core_we = 1; core_addr = 32'h30; core_wdata = 32'hC0FFEE;
        #1;
        chk("rlock_aux", aux_gnt, 1);
        chk("rlock_core", core_gnt, 0);
        #1;
        rst = 1;
        #1;
        chk("async_core_gnt", core_gnt, 0);
        chk("async_aux_gnt", aux_gnt, 0);
        chk("async_mem_we", mem_writeEnable, 0);
        chk("async_aux_rvalid", aux_rvalid, 0);
        chk("async_rdata", rdata, 0);
        cyc();
        cyc();
        rst = 0;
        #1;
        chk("post_rst_core", core_gnt, 1);
        chk("post_rst_aux", aux_gnt, 0);
        chk("post_rst_we", mem_writeEnable, 1);
        cyc();
        core_req = 0; aux_req = 0; aux_lock = 0;
        #1;
        chk("post_rst_rvalid", core_rvalid, 1);
        cyc();

        // Store on aux, immediately load same word on core.
        aux_req = 1; aux_we = 1; aux_addr = 32'h20; aux_wdata = 32'h12345678;
        #1;
        chk("fwd_st_gnt", aux_gnt, 1);
        cyc();
        aux_req = 0; core_req = 1; core_we = 0; core_addr = 32'h20;
        #1;
        chk("fwd_ld_gnt", core_gnt, 1);
        cyc();
        core_req = 0;
        #1;
        chk("fwd_rvalid", core_rvalid, 1);
        chk("fwd_rdata", rdata, 32'h12345678);
        cyc();
        cyc();

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
